// File: rtl/psc_checker.sv
// psc_checker: regenerates the dual-LFSR sequence from the shared seed, compares each rx word and tracks lock/loss + statistics.
// Latency: one cycle; every output is registered and reflects the word accepted on the previous rising edge.
// Backpressure: none; a word is accepted on every rx_valid cycle at full rate, and gaps freeze all state. Counters need PSC_CHK_ERRCNT_EN.
module psc_checker #(
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reproducible_button,
   input  logic [8:0]       seed,
   input  logic [3:0]       sequence_width,
   input  logic             rx_valid,
   input  logic [8:0]       rx_code,
   output logic             match,
   output logic             mismatch,
   output logic             locked,
   output logic             lost,
   output logic [CNT_W-1:0] word_count,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_LOCKED = 2'd1,
      ST_LOST   = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_run;
   logic [3:0] w_run_nxt;
   logic [3:0] w_run_inc;
   logic [8:0] r_c1;
   logic [8:0] r_c2;
   logic       r_loaded;
   logic       r_match;
   logic       r_mismatch;
   logic [8:0] w_perm;
   logic [8:0] w_sum;
   logic [8:0] w_mask;
   logic [8:0] w_expected;
   logic       w_hit;

   // Bit shuffle of the seed that initialises the second LFSR, same as the generator.
   assign w_perm = {seed[4], seed[6], seed[2], seed[3], seed[8], seed[7], seed[5], seed[0], seed[1]};
   assign w_sum  = r_c1 + r_c2 + {5'd0, sequence_width};
   assign w_hit  = (rx_code == w_expected);

   // Expected word: sum truncated to sequence_width bits; out-of-range widths expect all zeros.
   always_comb begin
      w_mask     = '0;
      w_expected = '0;
      if (sequence_width == 4'd9) begin
         w_expected = w_sum;
      end else if (sequence_width != 4'd0 && sequence_width < 4'd9) begin
         w_mask     = (9'd1 << sequence_width) - 9'd1;
         w_expected = w_sum & w_mask;
      end
   end

   // Local LFSR pair: first accepted word loads from the seed, later words shift once each.
   always_ff @(posedge clk) begin
      if (reproducible_button) begin
         r_c1     <= '0;
         r_c2     <= '0;
         r_loaded <= 1'b0;
      end else if (rx_valid) begin
         if (!r_loaded) begin
            r_c1     <= seed;
            r_c2     <= w_perm;
            r_loaded <= 1'b1;
         end else begin
            r_c1 <= {r_c1[1] ^ r_c1[0], r_c1[8:1]};
            r_c2 <= {r_c2[3] ^ r_c2[2], r_c2[8:1]};
         end
      end
   end

   // Per-word result pulses, low on idle cycles.
   always_ff @(posedge clk) begin
      if (reproducible_button) begin
         r_match    <= 1'b0;
         r_mismatch <= 1'b0;
      end else begin
         r_match    <= rx_valid & w_hit;
         r_mismatch <= rx_valid & ~w_hit;
      end
   end

   // Lock state register and consecutive-run counter.
   always_ff @(posedge clk) begin
      if (reproducible_button) begin
         r_state <= ST_HUNT;
         r_run   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= w_run_nxt;
      end
   end

   assign w_run_inc = r_run + 4'd1;

   // Lock/loss decisions: run counts matches while hunting and mismatches while locked.
   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      if (rx_valid) begin
         case (r_state)
            ST_HUNT: begin
               if (!w_hit) begin
                  w_run_nxt = '0;
               end else if (w_run_inc == 4'(LOCK_COUNT)) begin
                  w_state_nxt = ST_LOCKED;
                  w_run_nxt   = '0;
               end else begin
                  w_run_nxt = w_run_inc;
               end
            end
            ST_LOCKED: begin
               if (w_hit) begin
                  w_run_nxt = '0;
               end else if (w_run_inc == 4'(LOSS_COUNT)) begin
                  w_state_nxt = ST_LOST;
                  w_run_nxt   = '0;
               end else begin
                  w_run_nxt = w_run_inc;
               end
            end
            default: begin
               // LOST is sticky until reset.
               w_state_nxt = ST_LOST;
            end
         endcase
      end
   end

   assign match    = r_match;
   assign mismatch = r_mismatch;
   assign locked   = (r_state == ST_LOCKED);
   assign lost     = (r_state == ST_LOST);

`ifdef PSC_CHK_ERRCNT_EN
   logic [CNT_W-1:0] r_word_count;
   logic [CNT_W-1:0] r_err_count;

   // Saturating statistics, counted in every state.
   always_ff @(posedge clk) begin
      if (reproducible_button) begin
         r_word_count <= '0;
         r_err_count  <= '0;
      end else if (rx_valid) begin
         if (r_word_count != {CNT_W{1'b1}}) begin
            r_word_count <= r_word_count + 1'b1;
         end
         if (!w_hit && r_err_count != {CNT_W{1'b1}}) begin
            r_err_count <= r_err_count + 1'b1;
         end
      end
   end

   assign word_count = r_word_count;
   assign err_count  = r_err_count;
`else
   assign word_count = '0;
   assign err_count  = '0;
`endif

endmodule

// File: tb/tb_psc_checker.sv
// tb_psc_checker: directed vectors against hand-computed sequence tables for seed 9'h001.
// Counters run at CNT_W = 4 so saturation at 15 is reachable quickly.
// Counter expectations are 0 when PSC_CHK_ERRCNT_EN is not defined.
module tb_psc_checker;

   logic       clk = 1'b0;
   logic       rb;
   logic [8:0] seed;
   logic [3:0] width;
   logic       rx_valid;
   logic [8:0] rx_code;
   logic       match;
   logic       mismatch;
   logic       locked;
   logic       lost;
   logic [3:0] word_count;
   logic [3:0] err_count;

   int checks = 0;
   int errors = 0;

   // Expected words for seed 9'h001, derived by hand from the c1/c2 recurrences.
   logic [8:0] w9 [0:20];
   logic [8:0] w4 [0:20];

   psc_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(4)) dut (
      .clk                 (clk),
      .reproducible_button (rb),
      .seed                (seed),
      .sequence_width      (width),
      .rx_valid            (rx_valid),
      .rx_code             (rx_code),
      .match               (match),
      .mismatch            (mismatch),
      .locked              (locked),
      .lost                (lost),
      .word_count          (word_count),
      .err_count           (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected counter value for n events with a 4-bit saturating counter.
   function automatic logic [31:0] ce(input int n);
`ifdef PSC_CHK_ERRCNT_EN
      return (n > 15) ? 32'd15 : 32'(n);
`else
      return (n >= 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [8:0] code);
      rx_valid = 1'b1;
      rx_code  = code;
      cyc();
   endtask

   task automatic do_reset();
      rb       = 1'b1;
      rx_valid = 1'b0;
      cyc();
      rb       = 1'b0;
   endtask

   initial begin
      w9 = '{9'h009, 9'h00C, 9'h10A, 9'h089, 9'h049, 9'h029, 9'h019, 9'h011, 9'h00D, 9'h00B,
             9'h10A, 9'h189, 9'h0C9, 9'h069, 9'h039, 9'h021, 9'h015, 9'h00F, 9'h10C, 9'h08A, 9'h149};
      w4 = '{9'h004, 9'h007, 9'h005, 9'h004, 9'h004, 9'h004, 9'h004, 9'h00C, 9'h008, 9'h006,
             9'h005, 9'h004, 9'h004, 9'h004, 9'h004, 9'h00C, 9'h000, 9'h00A, 9'h007, 9'h005, 9'h004};

      rb = 1'b1; seed = 9'h001; width = 4'd9; rx_valid = 1'b0; rx_code = '0;
      cyc(); cyc();
      chk("rst_match", match, 0);
      chk("rst_mismatch", mismatch, 0);
      chk("rst_locked", locked, 0);
      chk("rst_lost", lost, 0);
      chk("rst_words", word_count, 0);
      chk("rst_errs", err_count, 0);
      rb = 1'b0;

      // Width 9: first three words, then lock, gap, and word-counter saturation.
      for (int i = 0; i < 3; i++) begin
         send(w9[i]);
         chk("a_match", match, 1);
         chk("a_mismatch", mismatch, 0);
      end
      chk("a_words", word_count, ce(3));
      chk("a_errs", err_count, ce(0));
      chk("a_not_locked", locked, 0);
      send(w9[3]);
      chk("a_locked", locked, 1);
      for (int i = 4; i < 7; i++) begin
         send(w9[i]);
         chk("a_match2", match, 1);
      end
      rx_valid = 1'b0;
      rx_code  = 9'h1FF;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("gap_match", match, 0);
         chk("gap_mismatch", mismatch, 0);
         chk("gap_locked", locked, 1);
      end
      for (int i = 7; i < 18; i++) begin
         send(w9[i]);
         chk("resume_match", match, 1);
      end
      chk("sat_words", word_count, ce(18));
      chk("resume_errs", err_count, ce(0));

      // Width 4: lock after exactly four matches, then error injection.
      do_reset();
      width = 4'd4;
      for (int i = 0; i < 4; i++) begin
         send(w4[i]);
         chk("b_match", match, 1);
         chk("b_locked", locked, (i == 3) ? 32'd1 : 32'd0);
      end
      send(w4[4]);
      send(w4[5]);
      send(w4[6] ^ 9'h001);
      chk("c_mismatch", mismatch, 1);
      chk("c_match_low", match, 0);
      send(w4[7] ^ 9'h001);
      send(w4[8]);
      chk("c_match", match, 1);
      chk("c_errs2", err_count, ce(2));
      chk("c_still_locked", locked, 1);
      send(w4[9] ^ 9'h001);
      send(w4[10] ^ 9'h001);
      chk("c_locked_2bad", locked, 1);
      chk("c_notlost_2bad", lost, 0);
      send(w4[11] ^ 9'h001);
      chk("c_lost", lost, 1);
      chk("c_unlocked", locked, 0);
      chk("c_errs5", err_count, ce(5));
      chk("c_words", word_count, ce(12));
      send(w4[12]);
      chk("lost_match", match, 1);
      chk("lost_sticky", lost, 1);

      // Reset together with a valid word while LOST.
      rb = 1'b1; rx_valid = 1'b1; rx_code = 9'h1FF;
      cyc();
      chk("e_match", match, 0);
      chk("e_mismatch", mismatch, 0);
      chk("e_locked", locked, 0);
      chk("e_lost", lost, 0);
      chk("e_words", word_count, 0);
      chk("e_errs", err_count, 0);
      rb = 1'b0; width = 4'd9;
      send(9'h009);
      chk("e_restart_match", match, 1);

      // Out-of-range widths expect zero; then error-counter saturation.
      do_reset();
      width = 4'd0;
      send(9'h000);
      chk("w0_match", match, 1);
      send(9'h001);
      chk("w0_mismatch", mismatch, 1);
      width = 4'd12;
      send(9'h000);
      chk("w12_match", match, 1);
      send(9'h001);
      chk("w12_mismatch", mismatch, 1);
      chk("f_errs", err_count, ce(2));
      width = 4'd0;
      for (int i = 0; i < 16; i++) send(9'h001);
      chk("sat_errs", err_count, ce(18));
      chk("f_words", word_count, ce(20));
      chk("f_not_locked", locked, 0);
      rx_valid = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
